// File: rtl/fp_scoreboard.sv
// In-order expected-result scoreboard for the FPU bench: FIFO of expected entries, relaxed-NaN compare, pass/error counters.
// Optional watchdog enabled by defining FP_SCOREBOARD_TIMEOUT_EN.
module fp_scoreboard #(
    parameter int XLEN    = 32,
    parameter int FLEN    = 5,
    parameter int DEPTH   = 8,
    parameter int MAXERR  = 1,
    parameter int TIMEOUT = 256
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [XLEN-1:0] exp_result,
    input  logic [FLEN-1:0] exp_flags,
    input  logic            exp_relax,
    input  logic            exp_last,
    input  logic            dut_ready,
    input  logic [XLEN-1:0] dut_result,
    input  logic [FLEN-1:0] dut_flags,
    output logic            mismatch,
    output logic [XLEN-1:0] mis_result_diff,
    output logic [FLEN-1:0] mis_flags_diff,
    output logic [31:0]     pass_cnt,
    output logic [31:0]     err_cnt,
    output logic            underflow,
    output logic            overflow,
    output logic            timeout,
    output logic            done,
    output logic            fail
);

    // state  | meaning
    // S_RUN  | accepting pushes/pops and comparing
    // S_DONE | final entry passed; frozen until reset
    // S_FAIL | error count reached MAXERR; frozen until reset
    typedef enum logic [1:0] {S_RUN = 2'd0, S_DONE = 2'd1, S_FAIL = 2'd2} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [31:0]   MAXERR_C = 32'(MAXERR);
    // Canonical NaN bits are exactly the exponent+quiet bits kept by a relaxed compare.
    localparam logic [63:0]   CNAN_W   = (XLEN == 64) ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
    localparam logic [XLEN-1:0] CNAN   = CNAN_W[XLEN-1:0];

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("fp_scoreboard: XLEN must be 32 or 64");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fp_scoreboard: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fp_scoreboard: TIMEOUT must be >= 1");
    end

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [FLEN-1:0] flags;
        logic            relax;
        logic            last;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    state_t          r_state;
    logic [31:0]     r_pass;
    logic [31:0]     r_err;
    logic            r_mismatch;
    logic [XLEN-1:0] r_rdiff;
    logic [FLEN-1:0] r_fdiff;
    logic            r_underflow;
    logic            r_overflow;
    logic            r_done;
    logic            r_fail;

    logic            w_active;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_ovf;
    logic            w_udf;
    logic            w_tmo;
    entry_t          w_head;
    logic [XLEN-1:0] w_raw;
    logic [XLEN-1:0] w_rdiff;
    logic [FLEN-1:0] w_fdiff;
    logic            w_mis;
    logic            w_pass;
    logic [1:0]      w_err_inc;
    logic [32:0]     w_err_sum;
    logic [31:0]     w_err_next;
    logic [31:0]     w_pass_next;
    logic            w_go_fail;
    logic            w_go_done;

    assign w_active = (r_state == S_RUN);
    assign w_full   = (r_count == DEPTH_C);
    assign w_empty  = (r_count == '0);
    assign w_pop    = w_active && dut_ready && !w_empty;
    assign w_push   = w_active && issue_valid && (!w_full || w_pop);
    assign w_ovf    = w_active && issue_valid && w_full && !w_pop;
    assign w_udf    = w_active && dut_ready && w_empty;

    assign w_head   = r_mem[r_rptr];
    assign w_raw    = dut_result ^ w_head.result;
    assign w_rdiff  = (w_head.relax && dut_result == CNAN) ? (w_raw & CNAN) : w_raw;
    assign w_fdiff  = dut_flags ^ w_head.flags;
    assign w_mis    = w_pop && ((w_rdiff != '0) || (w_fdiff != '0));
    assign w_pass   = w_pop && !w_mis;

    assign w_err_inc   = 2'(w_udf) + 2'(w_ovf) + 2'(w_mis) + 2'(w_tmo);
    assign w_err_sum   = {1'b0, r_err} + 33'(w_err_inc);
    assign w_err_next  = w_err_sum[32] ? 32'hFFFF_FFFF : w_err_sum[31:0];
    assign w_pass_next = (w_pass && r_pass != 32'hFFFF_FFFF) ? r_pass + 32'd1 : r_pass;
    assign w_go_fail   = (w_err_inc != 2'd0) && (w_err_next >= MAXERR_C);
    assign w_go_done   = w_pass && w_head.last;

    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_mem[r_wptr] <= {exp_result, exp_flags, exp_relax, exp_last};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_state     <= S_RUN;
            r_pass      <= '0;
            r_err       <= '0;
            r_mismatch  <= 1'b0;
            r_rdiff     <= '0;
            r_fdiff     <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
        end else if (w_active) begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            r_pass     <= w_pass_next;
            r_err      <= w_err_next;
            r_mismatch <= w_mis;
            if (w_mis) begin
                r_rdiff <= w_rdiff;
                r_fdiff <= w_fdiff;
            end
            if (w_udf) r_underflow <= 1'b1;
            if (w_ovf) r_overflow  <= 1'b1;
            if (w_go_fail) begin
                r_state <= S_FAIL;
                r_fail  <= 1'b1;
            end else if (w_go_done) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
            end
        end else begin
            r_mismatch <= 1'b0;
        end
    end

`ifdef FP_SCOREBOARD_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);
    logic [31:0] r_wdog;
    logic        r_timeout;
    logic [31:0] w_wdog_inc;

    assign w_wdog_inc = r_wdog + 32'd1;
    // With entries pending and no pop, dut_ready is necessarily low: an idle cycle.
    assign w_tmo      = w_active && !w_pop && !w_empty && (w_wdog_inc == TIMEOUT_C);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (w_active) begin
            if (w_pop || w_empty) r_wdog <= '0;
            else                  r_wdog <= w_wdog_inc;
            if (w_tmo) r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_tmo   = 1'b0;
    assign timeout = 1'b0;
`endif

    assign issue_ready     = !w_full;
    assign mismatch        = r_mismatch;
    assign mis_result_diff = r_rdiff;
    assign mis_flags_diff  = r_fdiff;
    assign pass_cnt        = r_pass;
    assign err_cnt         = r_err;
    assign underflow       = r_underflow;
    assign overflow        = r_overflow;
    assign done            = r_done;
    assign fail            = r_fail;

endmodule

// File: tb/tb_fp_scoreboard.sv
// Directed bench for fp_scoreboard (DEPTH=4, MAXERR=1, TIMEOUT=16); timeout scenario runs when FP_SCOREBOARD_TIMEOUT_EN is defined.
module tb_fp_scoreboard;

    logic        clock;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] exp_result;
    logic [4:0]  exp_flags;
    logic        exp_relax;
    logic        exp_last;
    logic        dut_ready;
    logic [31:0] dut_result;
    logic [4:0]  dut_flags;
    logic        mismatch;
    logic [31:0] mis_result_diff;
    logic [4:0]  mis_flags_diff;
    logic [31:0] pass_cnt;
    logic [31:0] err_cnt;
    logic        underflow;
    logic        overflow;
    logic        timeout;
    logic        done;
    logic        fail;

    int n_checks = 0;
    int n_fail   = 0;

    fp_scoreboard #(.XLEN(32), .FLEN(5), .DEPTH(4), .MAXERR(1), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .exp_result(exp_result), .exp_flags(exp_flags), .exp_relax(exp_relax), .exp_last(exp_last),
        .dut_ready(dut_ready), .dut_result(dut_result), .dut_flags(dut_flags),
        .mismatch(mismatch), .mis_result_diff(mis_result_diff), .mis_flags_diff(mis_flags_diff),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt),
        .underflow(underflow), .overflow(overflow), .timeout(timeout),
        .done(done), .fail(fail)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input logic iv, input logic [31:0] er, input logic [4:0] ef, input logic rl,
                       input logic lst, input logic dr, input logic [31:0] dres, input logic [4:0] dfl);
        issue_valid = iv; exp_result = er; exp_flags = ef; exp_relax = rl; exp_last = lst;
        dut_ready = dr; dut_result = dres; dut_flags = dfl;
        step();
        issue_valid = 1'b0; exp_result = '0; exp_flags = '0; exp_relax = 1'b0; exp_last = 1'b0;
        dut_ready = 1'b0; dut_result = '0; dut_flags = '0;
    endtask

    task automatic push(input logic [31:0] er, input logic [4:0] ef, input logic rl, input logic lst);
        cyc(1'b1, er, ef, rl, lst, 1'b0, 32'h0, 5'h0);
    endtask

    task automatic pop(input logic [31:0] dres, input logic [4:0] dfl);
        cyc(1'b0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b1, dres, dfl);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_issue_ready got %b exp 1", issue_ready); end
        n_checks++; if (pass_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_pass_cnt got %0d exp 0", pass_cnt); end
        n_checks++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_err_cnt got %0d exp 0", err_cnt); end
        n_checks++; if ({mismatch, underflow, overflow, timeout, done, fail} !== 6'b0) begin n_fail++; $display("FAIL rst_flags got %b exp 000000", {mismatch, underflow, overflow, timeout, done, fail}); end
        n_checks++; if ({mis_result_diff, mis_flags_diff} !== 37'h0) begin n_fail++; $display("FAIL rst_diffs got %h/%h exp 0/0", mis_result_diff, mis_flags_diff); end
    endtask

    task automatic test_var_latency();
        apply_reset();
        push(32'h3F800000, 5'h00, 1'b0, 1'b0);
        pop(32'h3F800000, 5'h00);
        n_checks++; if (pass_cnt !== 32'd1) begin n_fail++; $display("FAIL vl_pass1 got %0d exp 1", pass_cnt); end
        push(32'h40000000, 5'h01, 1'b0, 1'b0);
        step(); step(); step();
        pop(32'h40000000, 5'h01);
        n_checks++; if ({pass_cnt, done} !== {32'd2, 1'b0}) begin n_fail++; $display("FAIL vl_pass2 got %0d/%b exp 2/0", pass_cnt, done); end
        push(32'h7F800000, 5'h05, 1'b0, 1'b1);
        step();
        pop(32'h7F800000, 5'h05);
        n_checks++; if (pass_cnt !== 32'd3) begin n_fail++; $display("FAIL vl_pass3 got %0d exp 3", pass_cnt); end
        n_checks++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL vl_err got %0d exp 0", err_cnt); end
        n_checks++; if ({done, fail} !== 2'b10) begin n_fail++; $display("FAIL vl_done_fail got %b exp 10", {done, fail}); end
        // DONE is terminal: a stray pop on the empty FIFO is ignored
        pop(32'h7F800000, 5'h05);
        n_checks++; if ({pass_cnt, err_cnt, underflow, done} !== {32'd3, 32'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL vl_frozen got pass=%0d err=%0d udf=%b done=%b exp 3/0/0/1", pass_cnt, err_cnt, underflow, done); end
    endtask

    task automatic test_relaxed_nan();
        apply_reset();
        push(32'h7FC00001, 5'h00, 1'b1, 1'b0);
        push(32'hFFC00000, 5'h00, 1'b1, 1'b0);
        pop(32'h7FC00000, 5'h00);
        n_checks++; if ({mismatch, pass_cnt} !== {1'b0, 32'd1}) begin n_fail++; $display("FAIL nan_relax1 got mis=%b pass=%0d exp 0/1", mismatch, pass_cnt); end
        pop(32'h7FC00000, 5'h00);
        n_checks++; if ({pass_cnt, err_cnt} !== {32'd2, 32'd0}) begin n_fail++; $display("FAIL nan_relax2 got pass=%0d err=%0d exp 2/0", pass_cnt, err_cnt); end
        push(32'h7FC00001, 5'h00, 1'b0, 1'b0);
        pop(32'h7FC00000, 5'h00);
        n_checks++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL nan_strict_pulse got %b exp 1", mismatch); end
        n_checks++; if (mis_result_diff !== 32'h00000001) begin n_fail++; $display("FAIL nan_strict_diff got %h exp 00000001", mis_result_diff); end
        n_checks++; if ({err_cnt, fail} !== {32'd1, 1'b1}) begin n_fail++; $display("FAIL nan_strict_fail got err=%0d fail=%b exp 1/1", err_cnt, fail); end
        step();
        n_checks++; if ({mismatch, mis_result_diff} !== {1'b0, 32'h00000001}) begin n_fail++; $display("FAIL nan_pulse_hold got %b/%h exp 0/00000001", mismatch, mis_result_diff); end
    endtask

    task automatic test_flags_mismatch();
        apply_reset();
        push(32'h40000000, 5'h01, 1'b0, 1'b0);
        pop(32'h40000000, 5'h11);
        n_checks++; if ({mismatch, mis_result_diff, mis_flags_diff} !== {1'b1, 32'h0, 5'h10}) begin n_fail++; $display("FAIL flg_diff got %b/%h/%h exp 1/00000000/10", mismatch, mis_result_diff, mis_flags_diff); end
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(i), 5'(i), 1'b0, 1'b0);
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL fw_full_ready got %b exp 0", issue_ready); end
        cyc(1'b1, 32'h104, 5'd4, 1'b0, 1'b0, 1'b1, 32'h100, 5'd0);
        n_checks++; if ({pass_cnt, issue_ready, dut.r_count} !== {32'd1, 1'b0, 3'd4}) begin n_fail++; $display("FAIL fw_full_pair got pass=%0d rdy=%b cnt=%0d exp 1/0/4", pass_cnt, issue_ready, dut.r_count); end
        for (int k = 0; k < 10; k++)
            cyc(1'b1, 32'h105 + 32'(k), 5'(5 + k), 1'b0, 1'b0, 1'b1, 32'h101 + 32'(k), 5'(1 + k));
        n_checks++; if ({pass_cnt, err_cnt, overflow} !== {32'd11, 32'd0, 1'b0}) begin n_fail++; $display("FAIL fw_wrap got pass=%0d err=%0d ovf=%b exp 11/0/0", pass_cnt, err_cnt, overflow); end
        for (int k = 0; k < 4; k++) pop(32'h10B + 32'(k), 5'(11 + k));
        n_checks++; if ({pass_cnt, err_cnt, issue_ready} !== {32'd15, 32'd0, 1'b1}) begin n_fail++; $display("FAIL fw_drain got pass=%0d err=%0d rdy=%b exp 15/0/1", pass_cnt, err_cnt, issue_ready); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 4; i++) push(32'h200 + 32'(i), 5'h0, 1'b0, 1'b0);
        push(32'h204, 5'h0, 1'b0, 1'b0);
        n_checks++; if ({overflow, err_cnt, fail, issue_ready} !== {1'b1, 32'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL ovf got ovf=%b err=%0d fail=%b rdy=%b exp 1/1/1/0", overflow, err_cnt, fail, issue_ready); end
        apply_reset();
        n_checks++; if ({overflow, fail, issue_ready, err_cnt} !== {1'b0, 1'b0, 1'b1, 32'd0}) begin n_fail++; $display("FAIL ovf_reset got ovf=%b fail=%b rdy=%b err=%0d exp 0/0/1/0", overflow, fail, issue_ready, err_cnt); end
    endtask

    task automatic test_underflow();
        apply_reset();
        cyc(1'b1, 32'h3F800000, 5'h0, 1'b0, 1'b0, 1'b1, 32'h0, 5'h0);
        n_checks++; if ({underflow, err_cnt, fail} !== {1'b1, 32'd1, 1'b1}) begin n_fail++; $display("FAIL udf got udf=%b err=%0d fail=%b exp 1/1/1", underflow, err_cnt, fail); end
        n_checks++; if (dut.r_count !== 3'd1) begin n_fail++; $display("FAIL udf_count got %0d exp 1", dut.r_count); end
    endtask

`ifdef FP_SCOREBOARD_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        push(32'h3F800000, 5'h0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) step();
        n_checks++; if ({timeout, fail} !== 2'b00) begin n_fail++; $display("FAIL tmo_early got %b exp 00", {timeout, fail}); end
        step();
        n_checks++; if ({timeout, fail, err_cnt} !== {1'b1, 1'b1, 32'd1}) begin n_fail++; $display("FAIL tmo_fire got tmo=%b fail=%b err=%0d exp 1/1/1", timeout, fail, err_cnt); end
    endtask
`endif

    task automatic test_reset_mid_run();
        apply_reset();
        push(32'h11111111, 5'h1, 1'b0, 1'b0);
        push(32'h22222222, 5'h2, 1'b0, 1'b0);
        push(32'h33333333, 5'h3, 1'b0, 1'b0);
        apply_reset();
        n_checks++; if ({issue_ready, dut.r_count, pass_cnt, err_cnt} !== {1'b1, 3'd0, 32'd0, 32'd0}) begin n_fail++; $display("FAIL mid_rst got rdy=%b cnt=%0d pass=%0d err=%0d exp 1/0/0/0", issue_ready, dut.r_count, pass_cnt, err_cnt); end
        n_checks++; if ({mismatch, underflow, overflow, timeout, done, fail} !== 6'b0) begin n_fail++; $display("FAIL mid_rst_flags got %b exp 000000", {mismatch, underflow, overflow, timeout, done, fail}); end
        push(32'h12345678, 5'h3, 1'b0, 1'b1);
        pop(32'h12345678, 5'h3);
        n_checks++; if ({pass_cnt, err_cnt, done} !== {32'd1, 32'd0, 1'b1}) begin n_fail++; $display("FAIL mid_rst_after got pass=%0d err=%0d done=%b exp 1/0/1", pass_cnt, err_cnt, done); end
    endtask

    initial begin
        reset = 1'b1;
        issue_valid = 1'b0; exp_result = '0; exp_flags = '0; exp_relax = 1'b0; exp_last = 1'b0;
        dut_ready = 1'b0; dut_result = '0; dut_flags = '0;
        step();
        test_reset();
        test_var_latency();
        test_relaxed_nan();
        test_flags_mismatch();
        test_full_wrap();
        test_overflow();
        test_underflow();
`ifdef FP_SCOREBOARD_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_scoreboard.md
# fp_scoreboard

Self-checking result scoreboard for the floating-point unit bench. It replaces fixed-depth expected-value shift registers with a parametrised in-order FIFO, so the DUT may have any latency, including variable latency. Expected results and flags are pushed when an operation is issued and popped when the FPU asserts ready. The block compares results, including relaxed canonical-NaN matching, counts passes and errors, and reports done or fail status.

## Interface

**Parameters**
- `XLEN`, default 32: result width; only 32 and 64 are legal.
- `FLEN`, default 5: flag width (NV, DZ, OF, UF, NX).
- `DEPTH`, default 8: maximum outstanding operations; power of two, ≥2.
- `MAXERR`, default 1: error count at which the block enters FAIL.
- `TIMEOUT`, default 256: watchdog limit in cycles; used only with `FP_SCOREBOARD_TIMEOUT_EN`.

**Ports**
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `issue_valid` in 1: an operation is issued this cycle; push the expected entry.
- `issue_ready` out 1: FIFO not full.
- `exp_result` in XLEN: reference result.
- `exp_flags` in FLEN: reference flags.
- `exp_relax` in 1: NaN-relaxed compare allowed. Drive 0 for fcmp and fcvt_f2i.
- `exp_last` in 1: this entry is the final vector.
- `dut_ready` in 1: DUT result valid; pop and compare.
- `dut_result` in XLEN: DUT result.
- `dut_flags` in FLEN: DUT flags.
- `mismatch` out 1: one-cycle pulse on a compare failure.
- `mis_result_diff` out XLEN: masked XOR of the last failing compare.
- `mis_flags_diff` out FLEN: flags XOR of the last failing compare.
- `pass_cnt` out 32: number of passing compares.
- `err_cnt` out 32: number of errors (mismatch, underflow, overflow, timeout).
- `underflow` out 1: sticky; `dut_ready` arrived with the FIFO empty.
- `overflow` out 1: sticky; push attempted while full with no pop.
- `timeout` out 1: sticky watchdog expiry.
- `done` out 1: level; the last entry passed.
- `fail` out 1: level; the FAIL state has been reached.

## Operation

- **FIFO:** DEPTH entries of {result, flags, relax, last}. Read and write pointers are log2(DEPTH) bits with natural wrap; occupancy is a log2(DEPTH)+1-bit count.
- **Push:** occurs when `issue_valid` is high and either (count < DEPTH) or a pop happens in the same cycle. `issue_ready` is low only when count == DEPTH.
- **Overflow:** `issue_valid` while full with no pop sets `overflow`, increments `err_cnt`, and drops the entry.
- **Pop:** occurs on `dut_ready` when count > 0. There is no bypass: an entry pushed in cycle N is poppable from cycle N+1.
- **Underflow:** `dut_ready` with count == 0 sets `underflow` and increments `err_cnt`. This applies even if a push happens in the same cycle; the push still proceeds.
- **Compare:** diff = `dut_result` ^ exp.result.
  - If exp.relax is set and `dut_result` equals the canonical NaN, diff is masked to the exponent and quiet bit only.
  - XLEN=32: canonical NaN is 0x7FC00000 and the kept bits are [30:22].
  - XLEN=64: canonical NaN is 0x7FF8000000000000 and the kept bits are [62:51].
  - fdiff = `dut_flags` ^ exp.flags.
  - Pass if diff == 0 and fdiff == 0; otherwise increment `err_cnt` and pulse `mismatch`.
- **Counters:** saturate at all-ones.
- **State machine:**
  - RUN → DONE on a passing pop of an entry with last = 1.
  - RUN → FAIL when `err_cnt` reaches MAXERR.
  - If both conditions occur in the same cycle, FAIL wins.
  - DONE and FAIL are terminal until `reset`. In those states pushes and pops are ignored and counters freeze.

## Timing

- All outputs are registered. A compare on edge N updates `pass_cnt`, `err_cnt`, `mismatch`, the diff outputs, the sticky flags and the state, all visible after edge N.
- `mismatch` is high for exactly one cycle per failing pop.
- `mis_*` outputs hold their values until the next failure.
- `issue_ready` is derived from the registered count.
- **Reset:** on any edge with `reset`=1, mid-run or not:
  - pointers, count, counters and diff outputs clear to 0;
  - all sticky flags, `mismatch`, `done` and `fail` clear to 0;
  - `issue_ready` = 1;
  - state returns to RUN.
- Reset has priority over every other event.
- Throughput: one push and one pop per cycle are sustained indefinitely.

## Configuration

- **`FP_SCOREBOARD_TIMEOUT_EN` defined:**
  - A 32-bit watchdog counts cycles in which count > 0 and `dut_ready` = 0.
  - The watchdog clears on any pop or when count == 0.
  - On reaching TIMEOUT, it sets `timeout`, increments `err_cnt` once, and moves the block to FAIL.
- **`FP_SCOREBOARD_TIMEOUT_EN` undefined:** the watchdog is absent, `timeout` is constant 0, and the TIMEOUT parameter is ignored.

## Test plan

- **Variable-latency pass:** push 3 entries (0x3F800000/0x00, 0x40000000/0x01, 0x7F800000/0x05, last on the third); DUT returns them at latencies 1, 4 and 2 → `pass_cnt`=3, `err_cnt`=0, `done`=1 after the third pop, `fail`=0.
- **Relaxed NaN:** expected 0x7FC00001 with relax=1, DUT 0x7FC00000 → pass. Repeat with relax=0 → `mismatch` pulse, `mis_result_diff`=0x00000001, `fail`=1 with MAXERR=1.
- **Full and wrap:** DEPTH=4; push 4 → `issue_ready`=0. Push and pop together while full → accepted, count stays 4. Then 10 more push/pop pairs across the pointer wrap → all pass, `overflow`=0.
- **Underflow:** `dut_ready` with empty FIFO and simultaneous `issue_valid` → `underflow`=1, `err_cnt`=1, count=1 on the next cycle.
- **Timeout (macro on, TIMEOUT=16):** push 1 entry and hold `dut_ready`=0 → `timeout`=1 and `fail`=1 on the 16th idle cycle.
- **Reset mid-run:** assert `reset` for 1 cycle with 3 entries pending and `err_cnt`=0 → count=0, all outputs 0 except `issue_ready`=1; a subsequent push/pop passes.
